sprite_rom_arbiter: RTL

Shares one 256x8 combinational sprite bitmap ROM between up to four sprite renderers. Each request fetches one full 16-pixel sprite row as two byte reads. The block returns the row as a 16-bit word with a one-cycle acknowledge. It sits between the per-tank renderers and the single bitmap ROM in the top level, so multiple tanks can use one ROM instance. Arbitration is round-robin, one request in flight at a time.

---
 rtl/sprite_rom_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Round-robin share of one 256x8 combinational sprite ROM between NREQ
//   renderers. Each grant reads two bytes (lo at {row,0}, hi at {row,1}) and
//   returns them as a 16-bit row with a one-cycle ack. One fetch in flight.
//
// Ports
//   clk       pixel clock, rising edge
//   reset     synchronous, active-high
//   req       per-requester level request, held until ack
//   row_addr  per-requester {bitmap[2:0], row[3:0]}, slice i = [7i+6:7i]
//   ack       one-cycle pulse: data_out slice for that requester updated
//   data_out  per-requester row {hi, lo}, slice i = [16i+15:16i]
//   rom_addr  registered ROM address
//   rom_bits  ROM data, combinational from rom_addr
//   busy      high while a fetch is in progress
//   gnt_id    requester currently or last served
module sprite_rom_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [7*NREQ-1:0]    row_addr,
    output logic [NREQ-1:0]      ack,
    output logic [16*NREQ-1:0]   data_out,
    output logic [7:0]           rom_addr,
    input  logic [7:0]           rom_bits,
    output logic                 busy,
    output logic [1:0]           gnt_id
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2
    } state_t;

    state_t                 r_state, w_next;
    logic [1:0]             r_ptr, r_cur, r_gnt;
    logic [7:0]             r_rom_addr, r_lo;
    logic [NREQ-1:0]        r_ack;
    logic [NREQ-1:0][15:0]  r_data;

    logic [NREQ-1:0]        w_elig;
    logic                   w_any;
    logic [1:0]             w_win;
    logic [6:0]             w_win_row, w_cur_row;
    logic [1:0]             w_ptr_nxt;

    // (a + b) mod NREQ; both operands are already below NREQ.
    function automatic logic [1:0] wrap_add(input logic [1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NREQ) s = s - NREQ;
        return s[1:0];
    endfunction

    // A requester in its ack cycle still has req high; mask it so it is
    // not granted again before it has had a chance to drop req.
    assign w_elig = req & ~r_ack;

    // Scan ptr+NREQ-1 down to ptr so the last hit is the first in RR order.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (wrap_add(r_ptr, k) == 2'(i) && w_elig[i]) begin
                    w_any = 1'b1;
                    w_win = 2'(i);
                end
            end
        end
    end

    always_comb begin
        w_win_row = '0;
        w_cur_row = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == 2'(i)) w_win_row = row_addr[7*i +: 7];
            if (r_cur == 2'(i)) w_cur_row = row_addr[7*i +: 7];
        end
    end

    assign w_ptr_nxt = wrap_add(r_cur, 1);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_any) w_next = FETCH_LO;
            FETCH_LO: w_next = FETCH_HI;
            FETCH_HI: w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state != IDLE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_cur      <= '0;
            r_gnt      <= '0;
            r_rom_addr <= '0;
            r_lo       <= '0;
            r_ack      <= '0;
            r_data     <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cur      <= w_win;
                        r_gnt      <= w_win;
                        r_rom_addr <= {w_win_row, 1'b0};
                    end
                end
                FETCH_LO: begin
                    r_lo       <= rom_bits;
                    r_rom_addr <= {w_cur_row, 1'b1};
                end
                FETCH_HI: begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (r_cur == 2'(i)) begin
                            r_data[i] <= {rom_bits, r_lo};
                            r_ack[i]  <= 1'b1;
                        end
                    end
                    r_ptr <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign ack      = r_ack;
    assign data_out = r_data;
    assign rom_addr = r_rom_addr;
    assign gnt_id   = r_gnt;

endmodule
